// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg
// Shared types and constants for the gate truth-table sequencer:
//   - state_t      : sequencer FSM states
//   - LED_*        : bit positions of the gate block outputs inside dut_leds
//   - NUM_STEPS    : number of input combinations exercised
//   - EXPECTED     : expected {or,and,not_x0,xor} pattern per step
//   - leds_mismatch: compares a captured LED word against its expected value
package gate_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam int LED_XOR = 0;
   localparam int LED_NOT = 1;
   localparam int LED_AND = 2;
   localparam int LED_OR  = 3;

   localparam int NUM_STEPS = 4;

   // Step k drives x0=k[0], x1=k[1].
   localparam logic [3:0] EXPECTED [0:NUM_STEPS-1] = '{4'b0010, 4'b1001, 4'b1011, 4'b1100};

   // Returns 1 when any named LED differs from its expected level.
   function automatic logic leds_mismatch(input logic [3:0] seen, input logic [3:0] want);
      leds_mismatch = (seen[LED_XOR] != want[LED_XOR]) |
                      (seen[LED_NOT] != want[LED_NOT]) |
                      (seen[LED_AND] != want[LED_AND]) |
                      (seen[LED_OR]  != want[LED_OR]);
   endfunction

endpackage

// File: rtl/gate_truth_sequencer_debounce.sv
// button_debounce
// Stable-count filter: the output level follows the input only after the input
// has differed from the output for DEBOUNCE_CYCLES consecutive samples.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (output returns low)
//   din  - synchronized button level
//   dout - conditioned button level (registered)
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt_r;
   logic             level_r;

   // Count consecutive samples disagreeing with the accepted level; flip on the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= {CNT_W{1'b0}};
         level_r <= 1'b0;
      end else if (din == level_r) begin
         cnt_r   <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         cnt_r   <= {CNT_W{1'b0}};
         level_r <= din;
      end else begin
         cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign dout = level_r;

endmodule

// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer
// Push-button self-test for the two-input gate block: walks (x1,x0) through
// 00,01,10,11, lets each combination settle, captures the four LEDs and
// compares them with the expected truth table.
// Build option: define GATE_SEQ_DEBOUNCE_EN to insert button_debounce between
// the synchronizer and the edge detector.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   start_btn - raw push button, high = pressed
//   dut_x0/1  - gate block inputs
//   dut_leds  - gate block outputs [0]=xor [1]=not_x0 [2]=and [3]=or
//   busy      - high from first DRIVE cycle through REPORT
//   done      - one-cycle pulse in REPORT
//   pass      - all steps matched (held until next start)
//   fail_vec  - per-step mismatch flags (held until next start)
//   led_log   - captured LEDs, step k at [4k+3:4k] (held until next start)
module gate_truth_sequencer
   import gate_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES   = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_btn,
   output logic        dut_x0,
   output logic        dut_x1,
   input  logic [3:0]  dut_leds,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [3:0]  fail_vec,
   output logic [15:0] led_log
);

   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
         $error("SETTLE_CYCLES must be in 1..255");
      end
      if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
         $error("DEBOUNCE_CYCLES must be at least 2");
      end
   endgenerate

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   logic             btn_sync1_r, btn_sync2_r;
   logic             btn_cond_s;
   logic             btn_prev_r, btn_rise_r;
   state_t           state_r, state_nxt_s;
   logic [1:0]       step_r;
   logic [1:0]       x_r;
   logic [CNT_W-1:0] cnt_r;
   logic             settle_done_s;
   logic             mismatch_s;
   logic [3:0]       fail_nxt_s;
   logic             pass_r;
   logic [3:0]       fail_vec_r;
   logic [15:0]      led_log_r;
   logic             busy_s, done_s;

   // Two-flop synchronizer for the asynchronous button.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_sync1_r <= 1'b0;
         btn_sync2_r <= 1'b0;
      end else begin
         btn_sync1_r <= start_btn;
         btn_sync2_r <= btn_sync1_r;
      end
   end

`ifdef GATE_SEQ_DEBOUNCE_EN
   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_sync2_r),
      .dout (btn_cond_s)
   );
`else
   assign btn_cond_s = btn_sync2_r;
`endif

   // Registered rising-edge detector on the conditioned button level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_prev_r <= 1'b0;
         btn_rise_r <= 1'b0;
      end else begin
         btn_prev_r <= btn_cond_s;
         btn_rise_r <= btn_cond_s & ~btn_prev_r;
      end
   end

   assign settle_done_s = (cnt_r == CNT_W'(SETTLE_CYCLES - 1));

   // Compare the live LEDs against the current step and fold into the flags.
   always_comb begin
      mismatch_s         = leds_mismatch(dut_leds, EXPECTED[step_r]);
      fail_nxt_s         = fail_vec_r;
      fail_nxt_s[step_r] = mismatch_s;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; button edges outside IDLE are dropped.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    if (btn_rise_r)     state_nxt_s = DRIVE;  else state_nxt_s = IDLE;
         DRIVE:   if (settle_done_s)  state_nxt_s = SAMPLE; else state_nxt_s = DRIVE;
         SAMPLE:  if (step_r == 2'd3) state_nxt_s = REPORT; else state_nxt_s = DRIVE;
         REPORT:  state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM output decode from the state register.
   always_comb begin
      busy_s = 1'b0;
      done_s = 1'b0;
      case (state_r)
         IDLE:    begin busy_s = 1'b0; done_s = 1'b0; end
         DRIVE:   begin busy_s = 1'b1; done_s = 1'b0; end
         SAMPLE:  begin busy_s = 1'b1; done_s = 1'b0; end
         REPORT:  begin busy_s = 1'b1; done_s = 1'b1; end
         default: begin busy_s = 1'b0; done_s = 1'b0; end
      endcase
   end

   // Datapath: step index, gate inputs, settle counter and captured results.
   // pass is resolved on the final SAMPLE edge so it is valid alongside done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_r     <= 2'd0;
         x_r        <= 2'd0;
         cnt_r      <= {CNT_W{1'b0}};
         pass_r     <= 1'b0;
         fail_vec_r <= 4'd0;
         led_log_r  <= 16'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (btn_rise_r) begin
                  step_r     <= 2'd0;
                  x_r        <= 2'd0;
                  cnt_r      <= {CNT_W{1'b0}};
                  pass_r     <= 1'b0;
                  fail_vec_r <= 4'd0;
                  led_log_r  <= 16'd0;
               end
            end
            DRIVE: begin
               if (settle_done_s) cnt_r <= {CNT_W{1'b0}};
               else               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            SAMPLE: begin
               led_log_r[{step_r, 2'b00} +: 4] <= dut_leds;
               fail_vec_r                      <= fail_nxt_s;
               if (step_r != 2'd3) begin
                  step_r <= step_r + 2'd1;
                  x_r    <= step_r + 2'd1;
               end else begin
                  pass_r <= ~|fail_nxt_s;
               end
            end
            REPORT: begin
               step_r <= 2'd0;
            end
            default: begin
               step_r <= 2'd0;
            end
         endcase
      end
   end

   assign dut_x0   = x_r[0];
   assign dut_x1   = x_r[1];
   assign busy     = busy_s;
   assign done     = done_s;
   assign pass     = pass_r;
   assign fail_vec = fail_vec_r;
   assign led_log  = led_log_r;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench for gate_truth_sequencer: u_dut0 (SETTLE_CYCLES=2) drives a
// gate model with an optional stuck-at-0 AND output, u_dut1 (SETTLE_CYCLES=1)
// drives a correct gate model.
module tb_gate_truth_sequencer;

`ifdef GATE_SEQ_DEBOUNCE_EN
   localparam int BTN_LAT = 20;
   localparam int HOLD    = 30;
`else
   localparam int BTN_LAT = 4;
   localparam int HOLD    = 3;
`endif
   localparam int WIN = 60;

   logic clk = 1'b0;
   logic rst;
   logic btn0, btn1, stuck_and;
   logic x0_0, x1_0, busy0, done0, pass0;
   logic x0_1, x1_1, busy1, done1, pass1;
   logic [3:0]  leds0, leds1, fv0, fv1;
   logic [15:0] log0, log1;

   int n_cmp = 0;
   int n_bad = 0;

   int o_lat, o_rises, o_busy, o_done_at, o_ndone;
   logic o_pass_done;
   logic [3:0]  o_fv_b1;
   logic [15:0] o_log_b1;
   logic [1:0]  xlog [0:63];

   always #5 clk = ~clk;

   // Gate block models: {or, and, not_x0, xor}.
   always_comb begin
      leds0 = {x0_0 | x1_0, x0_0 & x1_0 & ~stuck_and, ~x0_0, x0_0 ^ x1_0};
      leds1 = {x0_1 | x1_1, x0_1 & x1_1, ~x0_1, x0_1 ^ x1_1};
   end

   gate_truth_sequencer #(.SETTLE_CYCLES(2), .DEBOUNCE_CYCLES(16)) u_dut0 (
      .clk(clk), .rst(rst), .start_btn(btn0), .dut_x0(x0_0), .dut_x1(x1_0),
      .dut_leds(leds0), .busy(busy0), .done(done0), .pass(pass0),
      .fail_vec(fv0), .led_log(log0));

   gate_truth_sequencer #(.SETTLE_CYCLES(1), .DEBOUNCE_CYCLES(16)) u_dut1 (
      .clk(clk), .rst(rst), .start_btn(btn1), .dut_x0(x0_1), .dut_x1(x1_1),
      .dut_leds(leds1), .busy(busy1), .done(done1), .pass(pass1),
      .fail_vec(fv1), .led_log(log1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_btn(input bit sel, input logic v);
      if (sel) btn1 = v;
      else     btn0 = v;
   endtask

   // Press at t=0 for `hold` cycles (plus optional re-press window) and record activity.
   task automatic observe(input bit sel, input int hold, input int re_on, input int re_off);
      logic b, d, bprev;
      o_lat = -1; o_rises = 0; o_busy = 0; o_done_at = -1; o_ndone = 0;
      o_pass_done = 1'b0; o_fv_b1 = 4'hF; o_log_b1 = 16'hFFFF; bprev = 1'b0;
      set_btn(sel, hold > 0);
      for (int t = 1; t <= WIN; t++) begin
         @(negedge clk);
         set_btn(sel, (t < hold) || (t >= re_on && t < re_off));
         b = sel ? busy1 : busy0;
         d = sel ? done1 : done0;
         if (b && !bprev) begin
            o_rises++;
            if (o_lat < 0) o_lat = t;
         end
         if (b && o_rises == 1) begin
            o_busy++;
            xlog[o_busy] = sel ? {x1_1, x0_1} : {x1_0, x0_0};
            if (o_busy == 1) begin
               o_fv_b1  = sel ? fv1 : fv0;
               o_log_b1 = sel ? log1 : log0;
            end
         end
         if (d) begin
            o_ndone++;
            if (o_done_at < 0) begin
               o_done_at   = o_busy;
               o_pass_done = sel ? pass1 : pass0;
            end
         end
         bprev = b;
      end
   endtask

   initial begin
      int cnt;
      rst = 1'b1; btn0 = 1'b0; btn1 = 1'b0; stuck_and = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy0), 32'd0);
      chk("reset_done", 32'(done0), 32'd0);
      chk("reset_pass", 32'(pass0), 32'd0);
      chk("reset_fv",   32'(fv0),   32'd0);
      chk("reset_log",  32'(log0),  32'd0);
      chk("reset_x",    32'({x1_0, x0_0}), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Correct model, single press.
      observe(1'b0, HOLD, 0, 0);
      chk("run1_latency", 32'(o_lat), 32'(BTN_LAT));
      chk("run1_runs",    32'(o_rises), 32'd1);
      chk("run1_busy",    32'(o_busy), 32'd13);
      chk("run1_done_at", 32'(o_done_at), 32'd13);
      chk("run1_ndone",   32'(o_ndone), 32'd1);
      chk("run1_pass_at_done", 32'(o_pass_done), 32'd1);
      chk("run1_pass",    32'(pass0), 32'd1);
      chk("run1_fv",      32'(fv0), 32'd0);
      chk("run1_log",     32'(log0), 32'hCB92);
      for (int b = 1; b <= 13; b++)
         chk($sformatf("run1_x_b%0d", b), 32'(xlog[b]), 32'((b - 1) / 3 > 3 ? 3 : (b - 1) / 3));

      // AND output stuck at 0.
      stuck_and = 1'b1;
      observe(1'b0, HOLD, 0, 0);
      chk("stuck_pass", 32'(pass0), 32'd0);
      chk("stuck_pass_at_done", 32'(o_pass_done), 32'd0);
      chk("stuck_fv",   32'(fv0), 32'h8);
      chk("stuck_slot3", 32'(log0[15:12]), 32'h8);
      chk("stuck_log",  32'(log0), 32'h8B92);
      stuck_and = 1'b0;

      // Re-press while busy; previous failing results must be cleared.
      observe(1'b0, HOLD, 8, 11);
      chk("repress_runs",  32'(o_rises), 32'd1);
      chk("repress_ndone", 32'(o_ndone), 32'd1);
      chk("repress_fv_b1", 32'(o_fv_b1), 32'd0);
      chk("repress_log_b1", 32'(o_log_b1), 32'd0);
      chk("repress_pass",  32'(pass0), 32'd1);
      chk("repress_log",   32'(log0), 32'hCB92);

      // Button held through REPORT must not retrigger.
      observe(1'b0, 40, 0, 0);
      chk("held_runs",  32'(o_rises), 32'd1);
      chk("held_ndone", 32'(o_ndone), 32'd1);
      chk("held_pass",  32'(pass0), 32'd1);

      // Reset asserted at busy cycle 6.
      btn0 = 1'b1;
      cnt = 0;
      while (!busy0 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("rst_run_started", 32'(busy0), 32'd1);
      btn0 = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_pre_x", 32'({x1_0, x0_0}), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(busy0), 32'd0);
      chk("rst_mid_done", 32'(done0), 32'd0);
      chk("rst_mid_x",    32'({x1_0, x0_0}), 32'd0);
      chk("rst_mid_fv",   32'(fv0), 32'd0);
      chk("rst_mid_log",  32'(log0), 32'd0);
      chk("rst_mid_pass", 32'(pass0), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (busy0 || done0) cnt++;
      end
      chk("rst_after_idle", 32'(cnt), 32'd0);
      observe(1'b0, HOLD, 0, 0);
      chk("rst_next_done_at", 32'(o_done_at), 32'd13);
      chk("rst_next_pass", 32'(pass0), 32'd1);
      chk("rst_next_log",  32'(log0), 32'hCB92);

      // SETTLE_CYCLES = 1.
      observe(1'b1, HOLD, 0, 0);
      chk("s1_latency", 32'(o_lat), 32'(BTN_LAT));
      chk("s1_busy",    32'(o_busy), 32'd9);
      chk("s1_done_at", 32'(o_done_at), 32'd9);
      chk("s1_pass",    32'(pass1), 32'd1);
      chk("s1_log",     32'(log1), 32'hCB92);
      for (int b = 1; b <= 9; b++)
         chk($sformatf("s1_x_b%0d", b), 32'(xlog[b]), 32'((b - 1) / 2 > 3 ? 3 : (b - 1) / 2));

`ifdef GATE_SEQ_DEBOUNCE_EN
      // Short glitches are filtered out.
      observe(1'b0, 5, 10, 15);
      chk("glitch_runs",  32'(o_rises), 32'd0);
      chk("glitch_ndone", 32'(o_ndone), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
